// File: rtl/fb_pkg.sv
// fb_pkg
// Shared constants and types for the double-buffered framebuffer slice.
// The width constants are also used by the display scanner and by the
// framebuffer instantiation, so they must stay in step with those blocks.
//   FB_DATA_WIDTH   : pixel word width (framebuffer wdata width)
//   FB_ADDR_WIDTH   : framebuffer address width
//   FB_FRAME_PIXELS : pixels per frame
//   fb_state_t      : writer FSM state encoding
package fb_pkg;

    localparam int FB_DATA_WIDTH   = 20;
    localparam int FB_ADDR_WIDTH   = 14;
    localparam int FB_FRAME_PIXELS = 16384;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        WAIT_SWAP = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fb_writer_stats.sv
// fb_writer_stats
// Event counters for the frame writer, only instantiated when the top is
// built with FB_WRITER_STATS_EN defined.
// Ports:
//   clk         : clock
//   rst         : synchronous active-high reset
//   swap_evt    : one-cycle pulse on each buffer swap
//   drop_evt    : one-cycle pulse on each discarded beat or resync
//   frame_count : swaps seen, wraps from 0xFFFF to 0
//   drop_count  : drops seen, saturates at 0xFFFF
module fb_writer_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        swap_evt,
    input  logic        drop_evt,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count
);

    // Frame counter wraps naturally; drop counter holds at all-ones so a
    // long-running badly behaved source cannot make it look healthy again.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (swap_evt) begin
                frame_count <= frame_count + 16'd1;
            end
            if (drop_evt && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/fb_writer.sv
// fb_writer
// Upstream stage of the double-buffered framebuffer. Accepts a valid/ready
// pixel stream with a start-of-frame marker, writes one full frame into the
// back buffer with sequential addresses, and flips the buffer selection only
// once the frame is complete and the scanner has finished its frame.
// Optional build macro: FB_WRITER_STATS_EN adds frame_count/drop_count.
// Ports:
//   clk           : clock, also the framebuffer write clock
//   rst           : synchronous active-high reset
//   s_data        : stream pixel
//   s_valid       : s_data valid
//   s_sof         : beat is the first pixel of a frame
//   s_ready       : block can accept a beat
//   rd_frame_done : scanner end-of-displayed-frame pulse
//   wdata         : framebuffer write data
//   waddr         : framebuffer write address
//   we            : framebuffer write enable
//   selection     : buffer select, 0 = write A / display B
//   resync        : pulse when an unexpected SOF restarts a frame
//   frame_count   : (stats build) swaps performed, wrapping
//   drop_count    : (stats build) discarded beats + resyncs, saturating
module fb_writer
    import fb_pkg::*;
#(
    parameter int DATA_WIDTH   = FB_DATA_WIDTH,
    parameter int ADDR_WIDTH   = FB_ADDR_WIDTH,
    parameter int FRAME_PIXELS = FB_FRAME_PIXELS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_sof,
    output logic                  s_ready,
    input  logic                  rd_frame_done,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  we,
    output logic                  selection,
    output logic                  resync
`ifdef FB_WRITER_STATS_EN
    ,
    output logic [15:0]           frame_count,
    output logic [15:0]           drop_count
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

    fb_state_t             state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt;
    logic [ADDR_WIDTH-1:0] waddr_nxt;
    logic                  we_nxt;
    logic                  sel_nxt;
    logic                  resync_nxt;
    logic                  accept;

    // Ready is a decode of the state register, forced low while reset is
    // held so nothing is accepted until the block is actually running.
    assign s_ready = !rst && (state != WAIT_SWAP);
    assign accept  = s_valid && s_ready;

    // State and output registers; every output is registered so the
    // framebuffer sees a write exactly one cycle after the accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            wdata     <= '0;
            waddr     <= '0;
            we        <= 1'b0;
            selection <= 1'b0;
            resync    <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            wdata     <= wdata_nxt;
            waddr     <= waddr_nxt;
            we        <= we_nxt;
            selection <= sel_nxt;
            resync    <= resync_nxt;
        end
    end

    // Next-state and next-output decode. An SOF always restarts at address
    // 0, even mid-frame. rd_frame_done is only honoured in WAIT_SWAP, so a
    // pulse coincident with the last beat is ignored and the last write is
    // always out before the selection flips.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        wdata_nxt  = wdata;
        waddr_nxt  = waddr;
        we_nxt     = 1'b0;
        sel_nxt    = selection;
        resync_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (accept && s_sof) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = '0;
                    wdata_nxt = s_data;
                    ptr_nxt   = ONE_ADDR;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (accept) begin
                    we_nxt    = 1'b1;
                    wdata_nxt = s_data;
                    if (s_sof) begin
                        waddr_nxt  = '0;
                        ptr_nxt    = ONE_ADDR;
                        resync_nxt = 1'b1;
                    end else begin
                        waddr_nxt = ptr;
                        if (ptr == LAST_ADDR) begin
                            ptr_nxt   = '0;
                            state_nxt = WAIT_SWAP;
                        end else begin
                            ptr_nxt = ptr + ONE_ADDR;
                        end
                    end
                end
            end
            WAIT_SWAP: begin
                if (rd_frame_done) begin
                    sel_nxt   = !selection;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef FB_WRITER_STATS_EN
    logic swap_evt;
    logic drop_evt;

    // A drop is either a non-SOF beat thrown away in IDLE or a resync.
    assign swap_evt = (state == WAIT_SWAP) && rd_frame_done;
    assign drop_evt = accept && (((state == IDLE) && !s_sof) ||
                                 ((state == WRITE) && s_sof));

    fb_writer_stats u_stats (
        .clk         (clk),
        .rst         (rst),
        .swap_evt    (swap_evt),
        .drop_evt    (drop_evt),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );
`endif

endmodule

// File: tb/tb_fb_writer.sv
// tb_fb_writer
// Self-checking bench for fb_writer with a 16-pixel frame. A behavioural
// model tracks frame progress as "is a frame open, how many pixels are in
// it, is a completed frame waiting for the scanner" and predicts every
// registered output one cycle after each stimulus cycle.
module tb_fb_writer;

    localparam int DW = 20;
    localparam int AW = 14;
    localparam int FP = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_sof = 1'b0;
    logic          s_ready;
    logic          rd_frame_done = 1'b0;
    logic [DW-1:0] wdata;
    logic [AW-1:0] waddr;
    logic          we;
    logic          selection;
    logic          resync;
`ifdef FB_WRITER_STATS_EN
    logic [15:0]   frame_count;
    logic [15:0]   drop_count;
`endif

    int errorCount = 0;
    int checkCount = 0;

    // Reference model state
    bit mFrameOpen;
    bit mFrameFull;
    bit mSel;
    int mPixels;
    int mFrames;
    int mDrops;

    always #5 clk = ~clk;

    fb_writer #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .FRAME_PIXELS (FP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_sof         (s_sof),
        .s_ready       (s_ready),
        .rd_frame_done (rd_frame_done),
        .wdata         (wdata),
        .waddr         (waddr),
        .we            (we),
        .selection     (selection),
        .resync        (resync)
`ifdef FB_WRITER_STATS_EN
        ,
        .frame_count   (frame_count),
        .drop_count    (drop_count)
`endif
    );

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mFrameOpen = 1'b0;
        mFrameFull = 1'b0;
        mSel       = 1'b0;
        mPixels    = 0;
        mFrames    = 0;
        mDrops     = 0;
    endtask

    task automatic countDrop();
        if (mDrops < 16'hFFFF) mDrops++;
    endtask

    // Hold reset for n cycles and check the reset values while it is held
    task automatic doReset(input int n);
        rst           = 1'b1;
        s_valid       = 1'b0;
        s_sof         = 1'b0;
        rd_frame_done = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_we", we, 0);
            checkOutput("rst_waddr", waddr, 0);
            checkOutput("rst_wdata", wdata, 0);
            checkOutput("rst_resync", resync, 0);
            checkOutput("rst_selection", selection, 0);
            checkOutput("rst_s_ready", s_ready, 0);
        end
        rst = 1'b0;
        modelReset();
    endtask

    // One clock of stimulus; predicts and checks outputs after the edge
    task automatic applyStimulus(input bit v, input bit sof,
                                 input logic [DW-1:0] d, input bit done);
        bit            accept;
        bit            expWe;
        bit            expResync;
        int            expAddr;
        logic [DW-1:0] expData;
        s_valid       = v;
        s_sof         = sof;
        s_data        = d;
        rd_frame_done = done;
        #1;
        checkOutput("s_ready", s_ready, {31'd0, !mFrameFull});
        accept    = v && !mFrameFull;
        expWe     = 1'b0;
        expResync = 1'b0;
        expAddr   = 0;
        expData   = d;
        if (accept) begin
            if (sof) begin
                if (mFrameOpen) begin
                    expResync = 1'b1;
                    countDrop();
                end
                expWe      = 1'b1;
                expAddr    = 0;
                mFrameOpen = 1'b1;
                mPixels    = 1;
            end else if (mFrameOpen) begin
                expWe   = 1'b1;
                expAddr = mPixels;
                mPixels++;
                if (mPixels == FP) begin
                    mFrameOpen = 1'b0;
                    mFrameFull = 1'b1;
                end
            end else begin
                countDrop();
            end
        end else if (mFrameFull && done) begin
            mFrameFull = 1'b0;
            mSel       = !mSel;
            mFrames    = (mFrames + 1) % 65536;
        end
        @(posedge clk);
        #1;
        checkOutput("we", we, {31'd0, expWe});
        if (expWe) begin
            checkOutput("waddr", waddr, expAddr);
            checkOutput("wdata", wdata, expData);
        end
        checkOutput("resync", resync, {31'd0, expResync});
        checkOutput("selection", selection, {31'd0, mSel});
`ifdef FB_WRITER_STATS_EN
        checkOutput("frame_count", frame_count, mFrames);
        checkOutput("drop_count", drop_count, mDrops);
`endif
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    endtask

    // Full frame starting with SOF; optional done pulse on the last beat
    task automatic sendFrame(input int base, input bit doneOnLast);
        for (int i = 0; i < FP; i++) begin
            applyStimulus(1'b1, i == 0, DW'(base + i),
                          doneOnLast && (i == FP - 1));
        end
    endtask

    initial begin
        modelReset();
        doReset(3);

        // Basic frame then swap
        $display("[TB] basic frame and swap");
        sendFrame(0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, DW'(20'h12345), 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("swap_sel_1", selection, 1);

        // Non-SOF beats in IDLE are dropped
        $display("[TB] idle drops");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, DW'(i), 1'b0);
        idleCycles(1);

        // SOF on the sixth beat restarts; done coincident with last beat
        $display("[TB] resync and coincident done");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, i == 0, DW'(20'h100 + i), 1'b0);
        for (int i = 0; i < FP; i++) begin
            applyStimulus(1'b1, i == 0, DW'(20'h200 + i), i == FP - 1);
        end
        checkOutput("no_swap_on_last", selection, 1);
        idleCycles(3);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("swap_sel_0", selection, 0);

        // Reset part-way through a frame
        $display("[TB] reset mid-frame");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, i == 0, DW'(20'h300 + i), 1'b0);
        doReset(1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        // Two complete frames each followed by a swap
        $display("[TB] two frames");
        for (int f = 0; f < 2; f++) begin
            sendFrame(20'h400 + f * 32, 1'b0);
            idleCycles(1);
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
        end
        checkOutput("two_swaps_sel", selection, 0);

        // Randomized traffic
        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                doReset(1);
            end else begin
                applyStimulus($urandom_range(0, 9) < 7,
                              $urandom_range(0, 24) == 0,
                              DW'($urandom),
                              $urandom_range(0, 7) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Upstream stage of the double-buffered framebuffer: accepts a valid/ready pixel stream with a start-of-frame marker and writes one full frame into the back buffer.
- Generates sequential write addresses and the write strobe.
- Owns the buffer `selection` bit and flips it only when the frame is complete and the display scanner reports end of its displayed frame, so the scanner never sees a torn frame.

Parameters:
- DATA_WIDTH, 20, pixel word width; matches framebuffer wdata.
- ADDR_WIDTH, 14, framebuffer address width.
- FRAME_PIXELS, 16384, pixels per frame; must be ≤ 2**ADDR_WIDTH and ≥ 2.

Ports:
- clk  in  1  single clock; also the framebuffer write clock.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_WIDTH  stream pixel.
- s_valid  in  1  s_data valid.
- s_sof  in  1  qualifies the beat as the first pixel of a frame.
- s_ready  out  1  block can accept a beat.
- rd_frame_done  in  1  one-cycle pulse from the scanner at the end of a displayed frame (same clock).
- wdata  out  DATA_WIDTH  framebuffer write data.
- waddr  out  ADDR_WIDTH  framebuffer write address.
- we  out  1  framebuffer write enable.
- selection  out  1  framebuffer buffer select; 0 = write buffer A / display buffer B.
- resync  out  1  one-cycle pulse when an unexpected SOF restarts a frame.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE; selection = 0; we = 0; waddr = 0; wdata = 0; resync = 0.
  - s_ready = 0 during reset and 1 in the first cycle after reset.
- A beat is accepted when s_valid && s_ready.
- All outputs are registered. An accepted beat appears on we/waddr/wdata exactly 1 cycle later, with we high for that one cycle only.
- States:
  - IDLE:
    - s_ready = 1.
    - Beats without s_sof are accepted and discarded (no we).
    - An accepted beat with s_sof is written at address 0, the internal pointer becomes 1, and the FSM goes to WRITE.
  - WRITE:
    - s_ready = 1.
    - Each accepted beat is written at the pointer, then the pointer increments.
    - An accepted beat with s_sof writes at address 0, sets the pointer to 1 and pulses resync; the state stays WRITE.
    - Acceptance of the beat at pointer FRAME_PIXELS-1 moves the FSM to WAIT_SWAP.
    - No wrap: the pointer never exceeds FRAME_PIXELS-1.
  - WAIT_SWAP:
    - s_ready = 0.
    - On rd_frame_done: selection toggles at the next clock edge and the FSM goes to IDLE.
- Swap ordering:
  - An rd_frame_done pulse coincident with acceptance of the last beat is ignored.
  - A swap requires a pulse seen while in WAIT_SWAP, which guarantees the last write has issued at least 1 cycle before selection changes.
- rd_frame_done in IDLE or WRITE: ignored.
- Back-pressure holds indefinitely in WAIT_SWAP; no timeout.
- Reset mid-frame: the partial frame is abandoned, selection returns to 0 and no further we is issued.
- selection changes only in the WAIT_SWAP→IDLE transition (or on reset).

Optional Feature:
- Macro: FB_WRITER_STATS_EN.
- When defined, two extra outputs are added:
  - frame_count [15:0]: increments on each swap, wraps at 0xFFFF→0.
  - drop_count [15:0]: increments on each discarded IDLE beat and each resync, saturating at 0xFFFF.
  - Both reset to 0.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Decomposition:
- Shared package/header fb_pkg:
  - FB_DATA_WIDTH = 20, FB_ADDR_WIDTH = 14, FB_FRAME_PIXELS = 16384.
  - State encoding constants: IDLE = 2'd0, WRITE = 2'd1, WAIT_SWAP = 2'd2.
  - The same width constants are used by the scanner and the framebuffer instantiation.
- No sub-module required.
- Stats counters optionally split into fb_writer_stats for the FB_WRITER_STATS_EN build.

Test Plan:
- FRAME_PIXELS=16, send 16 beats 0x00000..0x0000F with s_sof on the first, then pulse rd_frame_done -> we pulses at waddr 0..15 with matching wdata, 1-cycle latency; s_ready low after beat 15; selection 0→1 one cycle after the pulse.
- 3 beats without s_sof in IDLE -> no we, s_ready stays 1; drop_count = 3 when FB_WRITER_STATS_EN.
- s_sof asserted on the 6th beat of a frame -> resync pulses once; that beat is written at waddr 0; the frame completes after 15 more beats.
- rd_frame_done coincident with the 16th beat -> no swap; a second pulse 4 cycles later -> selection toggles.
- rst asserted at beat 8 -> we = 0 and selection = 0 on the next cycle; a new frame restarts cleanly at waddr 0.
- Two complete frames each followed by a swap -> selection back to 0; frame_count = 2.
